// File: rtl/rx_cpl_host_mem.sv
// Completion receiver for host-memory reads: realigns CplD payloads into
// 64-bit words, writes them to a tag-indexed chunk buffer and tracks per-tag progress.
module rx_cpl_host_mem (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  output logic        trn_rdst_rdy_n,
  input  logic [15:0] cfg_completer_id,
  output logic        buf_wr_en,
  output logic [9:0]  buf_wr_addr,
  output logic [63:0] buf_wr_data,
  output logic        chunk_done,
  output logic [3:0]  chunk_tag,
  output logic        cpl_err
);

  localparam int unsigned DW_W     = 32;
  localparam int unsigned QW_W     = 64;
  localparam int unsigned LEN_W    = 10;
  localparam int unsigned OFF_W    = 8;
  localparam int unsigned SUM_W    = 11;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned NUM_TAGS = 16;
  localparam int unsigned CHUNK_DW = 128;
  localparam logic [6:0]  FMT_TYPE_CPLD = 7'b1001010;

  typedef enum logic [1:0] {IDLE, HDR2, DATA, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                rdst_rdy_n_q, rdst_rdy_n_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                status_ok_q, status_ok_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DW_W-1:0]     hold_q, hold_d;
  logic [OFF_W-1:0]    off_q [NUM_TAGS];
  logic [OFF_W-1:0]    off_d [NUM_TAGS];
  logic                buf_wr_en_q, buf_wr_en_d;
  logic [ADDR_W-1:0]   buf_wr_addr_q, buf_wr_addr_d;
  logic [QW_W-1:0]     buf_wr_data_q, buf_wr_data_d;
  logic                chunk_done_q, chunk_done_d;
  logic [TAG_W-1:0]    chunk_tag_q, chunk_tag_d;
  logic                cpl_err_q, cpl_err_d;

  logic                accept, sof, eof, hdr_err;
  logic [TAG_W-1:0]    hdr_tag;
  logic [SUM_W-1:0]    off_sum;
  logic [OFF_W-1:0]    data_off, off_inc;

  assign accept  = ~trn_rsrc_rdy_n & ~rdst_rdy_n_q;
  assign sof     = ~trn_rsof_n;
  assign eof     = ~trn_reof_n;
  assign hdr_tag = trn_rd[43:40];
  assign off_sum = SUM_W'(off_q[hdr_tag]) + SUM_W'(len_q);
  assign hdr_err = !status_ok_q
                || (trn_rd[47:44] != 4'h0)
                || (trn_rd[63:48] != cfg_completer_id)
                || len_q[0]
                || (len_q == '0)
                || (off_sum > SUM_W'(CHUNK_DW));
  assign data_off = off_q[tag_q];
  assign off_inc  = data_off + OFF_W'(2);

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    rdst_rdy_n_d  = 1'b0;
    len_d         = len_q;
    status_ok_d   = status_ok_q;
    tag_d         = tag_q;
    hold_d        = hold_q;
    off_d         = off_q;
    buf_wr_en_d   = 1'b0;
    buf_wr_addr_d = buf_wr_addr_q;
    buf_wr_data_d = buf_wr_data_q;
    chunk_done_d  = 1'b0;
    chunk_tag_d   = chunk_tag_q;
    cpl_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && sof) begin
          if (trn_rd[62:56] == FMT_TYPE_CPLD) begin
            len_d       = trn_rd[41:32];
            status_ok_d = (trn_rd[15:13] == 3'b000);
            state_d     = eof ? IDLE : HDR2;
          end else if (!eof) begin
            state_d = DRAIN;
          end
        end
      end
      HDR2: begin
        if (accept) begin
          tag_d  = hdr_tag;
          hold_d = trn_rd[31:0];
          if (hdr_err) begin
            cpl_err_d = 1'b1;
            state_d   = eof ? IDLE : DRAIN;
          end else begin
            state_d   = eof ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          buf_wr_en_d   = 1'b1;
          buf_wr_addr_d = {tag_q, data_off[6:1]};
          buf_wr_data_d = {hold_q, trn_rd[63:32]};
          off_d[tag_q]  = off_inc;
          if (trn_rrem_n == 8'h00) hold_d = trn_rd[31:0];
          if (eof) begin
            state_d = IDLE;
            // Chunk complete: report it and rearm the tag for the next request
            if (off_inc == OFF_W'(CHUNK_DW)) begin
              chunk_done_d = 1'b1;
              chunk_tag_d  = tag_q;
              off_d[tag_q] = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rdst_rdy_n_q  <= 1'b1;
      len_q         <= '0;
      status_ok_q   <= 1'b0;
      tag_q         <= '0;
      hold_q        <= '0;
      for (int i = 0; i < NUM_TAGS; i++) off_q[i] <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      chunk_done_q  <= 1'b0;
      chunk_tag_q   <= '0;
      cpl_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdst_rdy_n_q  <= rdst_rdy_n_d;
      len_q         <= len_d;
      status_ok_q   <= status_ok_d;
      tag_q         <= tag_d;
      hold_q        <= hold_d;
      off_q         <= off_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_data_q <= buf_wr_data_d;
      chunk_done_q  <= chunk_done_d;
      chunk_tag_q   <= chunk_tag_d;
      cpl_err_q     <= cpl_err_d;
    end
  end

  assign trn_rdst_rdy_n = rdst_rdy_n_q;
  assign buf_wr_en      = buf_wr_en_q;
  assign buf_wr_addr    = buf_wr_addr_q;
  assign buf_wr_data    = buf_wr_data_q;
  assign chunk_done     = chunk_done_q;
  assign chunk_tag      = chunk_tag_q;
  assign cpl_err        = cpl_err_q;

endmodule

// File: doc/rx_cpl_host_mem.md
# rx_cpl_host_mem

Completion receiver for host-memory reads: consumes CplD TLPs on the 64-bit TRN RX interface and returns the payload of the 512-byte (128 DW) read requests issued by the TX read-request engine, one request per tag 0-15. It realigns the 3-DW-header payload into 64-bit words and writes them into a 16-slot × 512-byte chunk buffer addressed by tag. It tracks per-tag progress and pulses `chunk_done` when a tag's 128 DWs have all arrived. Sole consumer of completions on RX; other TLP types are skipped.

## Interface
- No parameters. Chunk size is 128 DW, tags are 0-15, buffer depth is 1024 qwords.
- trn_clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- trn_rd  in  64  RX data; big-endian DW order: [63:32] is the first DW.
- trn_rrem_n  in  8  RX remainder; 8'h00 means 2 DW valid, 8'h0F means only [63:32] valid.
- trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n  in  1 each  RX framing, active-low.
- trn_rdst_rdy_n  out  1  ready to the core.
- cfg_completer_id  in  16  own ID; compared against the requester ID.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  10  {tag[3:0], qword_offset[5:0]}.
- buf_wr_data  out  64  [63:32] = lower-address DW.
- chunk_done  out  1  one-cycle pulse.
- chunk_tag  out  4  tag of the completed chunk; valid with `chunk_done`.
- cpl_err  out  1  one-cycle pulse on a dropped completion.

## Operation
- A beat is accepted when `trn_rsrc_rdy_n==0` and `trn_rdst_rdy_n==0`. `trn_rdst_rdy_n` is 1 in reset, then 0 from the first clock after reset release. No backpressure.
- FSM states: IDLE, HDR2, DATA, DRAIN. All transitions happen only on accepted beats.
- IDLE:
  - Beats without SOF are ignored.
  - On SOF, decode `trn_rd[62:56]`:
    - If it equals 7'b10_01010 (CplD), latch length = `trn_rd[41:32]`, check status `trn_rd[15:13]==0`, and go to HDR2.
    - Otherwise go to DRAIN. An SOF+EOF beat stays in IDLE.
- HDR2:
  - Latch tag = `trn_rd[47:40]` and hold = `trn_rd[31:0]` (payload DW0).
  - Error if any of the following: status≠0; tag[7:4]≠0; `trn_rd[63:48]`≠`cfg_completer_id`; length odd or 0; off[tag]+length>128.
  - On error: pulse `cpl_err`, make no writes, leave off[tag] unchanged, go to DRAIN (or to IDLE if EOF).
  - Otherwise go to DATA.
- DATA:
  - Each accepted beat writes data = {hold, `trn_rd[63:32]`}, addr = {tag, off[tag][6:1]}.
  - Then off[tag] += 2 and hold <= `trn_rd[31:0]`.
  - On the EOF beat (`trn_rrem_n`=8'h0F), only [63:32] is used; return to IDLE.
  - A completion of length L produces exactly L/2 writes.
- Chunk completion: if off[tag] reaches 128 on the EOF write, pulse `chunk_done` with `chunk_tag`=tag and set off[tag] to 0.
- DRAIN: discard beats until EOF, then go to IDLE.
- Counters: off[0..15] are 8 bits each, reset to 0. Completions for different tags may interleave at TLP granularity.
- A malformed EOF arriving early in DATA returns to IDLE. Writes already issued remain; off[] is not rolled back.
- Reset mid-TLP: everything clears. Remaining beats without SOF are ignored in IDLE.

## Timing
- All outputs are registered. Reset values: `trn_rdst_rdy_n`=1, `buf_wr_en`=0, `buf_wr_addr`=0, `buf_wr_data`=0, `chunk_done`=0, `chunk_tag`=0, `cpl_err`=0.
- `buf_wr_en` asserts one cycle after each accepted DATA beat. Full throughput is one qword per clock.
- `chunk_done` is asserted in the same cycle as the final `buf_wr_en` of the chunk.
- `cpl_err` is asserted one cycle after the HDR2 beat.
- A `trn_rsrc_rdy_n`=1 gap inside a TLP holds all state; no write is issued for that cycle.
- Back-to-back TLPs (EOF followed by SOF on the next clock) are accepted with no bubble.

## Test plan
- Single 128-DW CplD, tag 3, payload DW n = n: 64 writes, addr 0xC0-0xFF, first data 0x00000000_00000001. `chunk_done` with `chunk_tag`=3 on the 64th write.
- Tag 5 split into 8 completions of 16 DW (RCB 64B), interleaved with tag 6 split the same way: 64 writes per tag at the correct offsets. Exactly one `chunk_done` per tag, after that tag's last TLP.
- Random `trn_rsrc_rdy_n` gaps in a 32-DW CplD: write count and data identical to the gap-free run.
- Error cases, each giving a `cpl_err` pulse, zero writes, and off[] unchanged:
  - status=3'b001;
  - tag=0x12;
  - length=7;
  - length=64 with off[tag]=96.
- MWr TLP of 4 beats followed immediately by a CplD: MWr fully drained with no writes; CplD processed normally.
- `reset_n` pulsed mid-DATA, then orphan beats, then a fresh CplD: orphans ignored, off[] back to 0, new CplD written from offset 0.
